// File: rtl/axi_write_master.sv
// axi_write_master
//   Moves a 64-byte-aligned block of stream data to memory over an AXI4 write
//   channel. Bursts are limited to BURST_LEN beats and never cross a 4 KB page.
//   Up to MAX_OUTSTANDING bursts may be waiting for their write response.
//
// Ports
//   aclk, areset               clock, asynchronous active-high reset
//   wmst_req                   one-cycle start pulse (ignored while busy)
//   wmst_xfer_addr/size        start byte address / byte count (low 6 bits ignored)
//   axis_slv_*                 512-bit source stream
//   m_axi_aw*/w*/b*            AXI4 write address, data and response channels
//   wmst_busy                  transfer in progress, through the done cycle
//   wmst_done                  one-cycle completion pulse
//   wmst_error                 sticky: some write response was not OKAY
module axi_write_master #(
   parameter int BURST_LEN       = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic         aclk,
   input  logic         areset,
   input  logic         wmst_req,
   input  logic [63:0]  wmst_xfer_addr,
   input  logic [63:0]  wmst_xfer_size,
   input  logic         axis_slv_tvalid,
   output logic         axis_slv_tready,
   input  logic [511:0] axis_slv_tdata,
   output logic         m_axi_awvalid,
   input  logic         m_axi_awready,
   output logic [63:0]  m_axi_awaddr,
   output logic [7:0]   m_axi_awlen,
   output logic [2:0]   m_axi_awsize,
   output logic [1:0]   m_axi_awburst,
   output logic         m_axi_wvalid,
   input  logic         m_axi_wready,
   output logic [511:0] m_axi_wdata,
   output logic [63:0]  m_axi_wstrb,
   output logic         m_axi_wlast,
   input  logic         m_axi_bvalid,
   output logic         m_axi_bready,
   input  logic [1:0]   m_axi_bresp,
   output logic         wmst_busy,
   output logic         wmst_done,
   output logic         wmst_error
);

   typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_WAIT_B} state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [63:0]  r_addr;
   logic [57:0]  r_beats_rem;    // beats not yet covered by an issued AW
   logic [8:0]   r_burst_beats;  // beat count of the burst currently in W
   logic [8:0]   r_beat_cnt;
   logic [3:0]   r_outstanding;
   logic         r_zero_done;
   logic         r_error;

   logic [57:0]  w_total_beats;
   logic         w_req_ok;
   logic [6:0]   w_to_page;
   logic [8:0]   w_rem_clip;
   logic [8:0]   w_burst_beats;
   logic [8:0]   w_len_m1;
   logic         w_aw_hs;
   logic         w_w_hs;
   logic         w_last_hs;
   logic         w_b_dec;
   logic         w_unused;

   assign w_total_beats = wmst_xfer_size[63:6];
   // A zero-length request finishes in IDLE, so the done cycle must block a new start.
   assign w_req_ok      = wmst_req && (r_state == S_IDLE) && !r_zero_done;

   // Beats left before the next 4 KB page boundary: 1..64.
   assign w_to_page     = 7'd64 - {1'b0, r_addr[11:6]};
   assign w_rem_clip    = (r_beats_rem > 58'(BURST_LEN)) ? 9'(BURST_LEN) : r_beats_rem[8:0];
   assign w_burst_beats = (w_rem_clip > {2'b00, w_to_page}) ? {2'b00, w_to_page} : w_rem_clip;
   assign w_len_m1      = w_burst_beats - 9'd1;

   assign w_aw_hs   = m_axi_awvalid & m_axi_awready;
   assign w_w_hs    = m_axi_wvalid & m_axi_wready;
   assign w_last_hs = w_w_hs & m_axi_wlast;
   assign w_b_dec   = m_axi_bvalid && (r_outstanding != 4'd0);

   assign m_axi_awaddr  = r_addr;
   assign m_axi_awlen   = w_len_m1[7:0];
   assign m_axi_awsize  = 3'b110;
   assign m_axi_awburst = 2'b01;
   assign m_axi_wdata   = axis_slv_tdata;
   assign m_axi_wstrb   = '1;
   assign m_axi_bready  = 1'b1;
   assign wmst_busy     = (r_state != S_IDLE) || r_zero_done;
   assign wmst_error    = r_error;

   assign w_unused = ^{wmst_xfer_addr[5:0], wmst_xfer_size[5:0], w_len_m1[8]};

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      m_axi_awvalid   = 1'b0;
      m_axi_wvalid    = 1'b0;
      m_axi_wlast     = 1'b0;
      axis_slv_tready = 1'b0;
      wmst_done       = r_zero_done;
      case (r_state)
         S_IDLE: begin
            if (w_req_ok && (w_total_beats != '0)) w_state_nxt = S_AW;
         end
         S_AW: begin
            m_axi_awvalid = (r_outstanding < 4'(MAX_OUTSTANDING));
            if (w_aw_hs) w_state_nxt = S_W;
         end
         S_W: begin
            m_axi_wvalid    = axis_slv_tvalid;
            axis_slv_tready = m_axi_wready;
            m_axi_wlast     = (r_beat_cnt == (r_burst_beats - 9'd1));
            // r_beats_rem already excludes the burst being written.
            if (w_last_hs) w_state_nxt = (r_beats_rem != '0) ? S_AW : S_WAIT_B;
         end
         S_WAIT_B: begin
            if (r_outstanding == 4'd0) begin
               wmst_done   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_addr        <= '0;
         r_beats_rem   <= '0;
         r_burst_beats <= '0;
         r_beat_cnt    <= '0;
         r_outstanding <= '0;
         r_zero_done   <= 1'b0;
         r_error       <= 1'b0;
      end else begin
         if (w_req_ok) begin
            r_addr      <= {wmst_xfer_addr[63:6], 6'b0};
            r_beats_rem <= w_total_beats;
         end else if (w_aw_hs) begin
            r_addr      <= r_addr + {49'b0, w_burst_beats, 6'b0};
            r_beats_rem <= r_beats_rem - {49'b0, w_burst_beats};
         end

         if (w_aw_hs) begin
            r_burst_beats <= w_burst_beats;
            r_beat_cnt    <= '0;
         end else if (w_w_hs) begin
            r_beat_cnt <= r_beat_cnt + 9'd1;
         end

         r_zero_done <= w_req_ok && (w_total_beats == '0);

         case ({w_aw_hs, w_b_dec})
            2'b10:   r_outstanding <= r_outstanding + 4'd1;
            2'b01:   r_outstanding <= r_outstanding - 4'd1;
            default: r_outstanding <= r_outstanding;
         endcase

         if (w_req_ok) begin
            r_error <= 1'b0;
         end else if (m_axi_bvalid && (m_axi_bresp != 2'b00)) begin
            r_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi_write_master.sv
module tb_axi_write_master;
   localparam int BL = 16;
   localparam int MO = 4;

   logic         aclk = 1'b0;
   logic         areset;
   logic         wmst_req;
   logic [63:0]  wmst_xfer_addr, wmst_xfer_size;
   logic         tvalid, tready;
   logic [511:0] tdata;
   logic         awvalid, awready;
   logic [63:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic         wvalid, wready, wlast;
   logic [511:0] wdata;
   logic [63:0]  wstrb;
   logic         bvalid, bready;
   logic [1:0]   bresp;
   logic         busy, done, error;

   axi_write_master #(.BURST_LEN(BL), .MAX_OUTSTANDING(MO)) dut (
      .aclk(aclk), .areset(areset),
      .wmst_req(wmst_req), .wmst_xfer_addr(wmst_xfer_addr), .wmst_xfer_size(wmst_xfer_size),
      .axis_slv_tvalid(tvalid), .axis_slv_tready(tready), .axis_slv_tdata(tdata),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
      .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
      .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
      .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
      .wmst_busy(busy), .wmst_done(done), .wmst_error(error)
   );

   always #5 aclk = ~aclk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] pat(input int i);
      logic [63:0] w;
      w = {32'hC0DE0000 ^ 32'(i), 32'(i)};
      return {8{w}};
   endfunction

   // Slave / stream model state
   bit          stall = 1'b0;
   int          bdelay = 2;
   int          err_burst = -1;
   int          cyc = 0;
   int          n_aw, n_w, n_done, wb, wk, outst, max_outst, s_idx;
   int          data_err, last_err, gate_err, stab_err, seq_err;
   logic        err_at_done, busy_at_done;
   logic [63:0] aw_addr [256];
   int          aw_len  [256];
   int          bq_due  [$];
   logic [1:0]  bq_resp [$];
   logic        aw_pend = 1'b0;
   logic [63:0] pend_addr;
   logic [7:0]  pend_len;

   // Inputs change on the falling edge; outputs are observed 1 ns later, and
   // any handshake seen then completes on the following rising edge.
   always @(negedge aclk) begin
      if (stall) begin
         awready = ($urandom_range(0, 1) == 1);
         wready  = ($urandom_range(0, 3) != 0);
         tvalid  = ($urandom_range(0, 3) != 0);
      end else begin
         awready = 1'b1;
         wready  = 1'b1;
         tvalid  = 1'b1;
      end
      tdata = pat(s_idx);
      if (bq_due.size() > 0 && bq_due[0] <= cyc) begin
         bvalid = 1'b1;
         bresp  = bq_resp[0];
      end else begin
         bvalid = 1'b0;
         bresp  = 2'b00;
      end
      #1;
      if (areset) begin
         aw_pend = 1'b0;
      end else begin
         if (aw_pend && !(awvalid && awaddr == pend_addr && awlen == pend_len)) stab_err++;
         if (awvalid && outst >= MO) gate_err++;
         if (awvalid && awready) begin
            if (n_aw < 256) begin
               aw_addr[n_aw] = awaddr;
               aw_len[n_aw]  = int'(awlen);
            end
            n_aw++;
            outst++;
            aw_pend = 1'b0;
         end else if (awvalid) begin
            aw_pend   = 1'b1;
            pend_addr = awaddr;
            pend_len  = awlen;
         end else begin
            aw_pend = 1'b0;
         end
         if (tvalid && (tready !== (wvalid & wready))) seq_err++;
         if (wvalid && wready) begin
            if (wb >= n_aw || wb >= 256) begin
               seq_err++;
            end else begin
               if (wdata !== pat(n_w)) data_err++;
               if (wlast !== (wk == aw_len[wb])) last_err++;
               if (wk == aw_len[wb]) begin
                  bq_due.push_back(cyc + bdelay);
                  bq_resp.push_back((wb == err_burst) ? 2'b10 : 2'b00);
                  wk = 0;
                  wb++;
               end else begin
                  wk++;
               end
            end
            n_w++;
         end
         if (tvalid && tready) s_idx++;
         if (bvalid) begin
            void'(bq_due.pop_front());
            void'(bq_resp.pop_front());
            if (outst == 0) seq_err++;
            else outst--;
         end
         if (outst > max_outst) max_outst = outst;
         if (done) begin
            n_done++;
            err_at_done  = error;
            busy_at_done = busy;
         end
      end
      cyc++;
   end

   task automatic start(input logic [63:0] a, input logic [63:0] s);
      @(posedge aclk); #1;
      n_aw = 0; n_w = 0; wb = 0; wk = 0; n_done = 0; s_idx = 0; max_outst = 0;
      data_err = 0; last_err = 0; gate_err = 0; stab_err = 0; seq_err = 0;
      err_at_done = 1'b0; busy_at_done = 1'b0;
      wmst_xfer_addr = a;
      wmst_xfer_size = s;
      wmst_req = 1'b1;
      @(posedge aclk); #1;
      wmst_req = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && n_done == 0; i++) @(posedge aclk);
      repeat (5) @(posedge aclk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      areset = 1'b1; wmst_req = 1'b0; wmst_xfer_addr = '0; wmst_xfer_size = '0;
      n_aw = 0; n_w = 0; wb = 0; wk = 0; n_done = 0; outst = 0; max_outst = 0; s_idx = 0;
      data_err = 0; last_err = 0; gate_err = 0; stab_err = 0; seq_err = 0;
      err_at_done = 1'b0; busy_at_done = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_outs", 64'({awvalid, wvalid, wlast, tready, busy, done, error}), 64'h0);
      chk("const_awsize_awburst_bready", 64'({awsize, awburst, bready}), 64'b110_01_1);
      chk("const_wstrb", wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
      areset = 1'b0;

      // Single aligned 16-beat burst, plus a start pulse while busy that must be ignored
      start(64'h1000, 64'h400);
      repeat (4) @(posedge aclk);
      #1;
      wmst_xfer_addr = 64'h8000; wmst_xfer_size = 64'h40; wmst_req = 1'b1;
      @(posedge aclk); #1;
      wmst_req = 1'b0;
      wait_done(300);
      chk("c027_done", 64'(n_done), 64'd1);
      chk("c027_n_aw", 64'(n_aw), 64'd1);
      chk("c027_awaddr", aw_addr[0], 64'h1000);
      chk("c027_awlen", 64'(aw_len[0]), 64'd15);
      chk("c027_n_w", 64'(n_w), 64'd16);
      chk("c027_wlast_err", 64'(last_err), 64'd0);
      chk("c027_data_err", 64'(data_err), 64'd0);
      chk("c027_busy_at_done", 64'(busy_at_done), 64'd1);
      chk("c027_busy_after", 64'(busy), 64'd0);

      // 1023 beats: 63 full bursts then one of 15
      start(64'h0, 64'hFFC0);
      wait_done(5000);
      chk("c028_done", 64'(n_done), 64'd1);
      chk("c028_n_aw", 64'(n_aw), 64'd64);
      chk("c028_n_w", 64'(n_w), 64'd1023);
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         if (aw_addr[i] !== 64'(i) * 64'h400) bad++;
         if (aw_len[i] != ((i == 63) ? 14 : 15)) bad++;
      end
      chk("c028_burst_table", 64'(bad), 64'd0);
      chk("c028_last_awlen", 64'(aw_len[63]), 64'd14);
      chk("c028_wlast_err", 64'(last_err), 64'd0);

      // 4 beats split at the 4 KB boundary
      start(64'h0FC0, 64'h100);
      wait_done(200);
      chk("c029_done", 64'(n_done), 64'd1);
      chk("c029_n_aw", 64'(n_aw), 64'd2);
      chk("c029_aw0", {aw_addr[0][55:0], 8'(aw_len[0])}, {56'h0FC0, 8'd0});
      chk("c029_aw1", {aw_addr[1][55:0], 8'(aw_len[1])}, {56'h1000, 8'd2});
      chk("c029_n_w", 64'(n_w), 64'd4);
      chk("c029_wlast_err", 64'(last_err), 64'd0);

      // Slow responses: outstanding limit must be reached and respected
      bdelay = 200;
      start(64'h0, 64'h4000);
      wait_done(4000);
      chk("c030a_done", 64'(n_done), 64'd1);
      chk("c030a_max_outst", 64'(max_outst), 64'd4);
      chk("c030a_gate_err", 64'(gate_err), 64'd0);
      chk("c030a_n_w", 64'(n_w), 64'd256);

      // Random stalls on every channel, B delayed 50 cycles
      stall = 1'b1;
      bdelay = 50;
      start(64'h0, 64'h4000);
      wait_done(6000);
      chk("c030b_done", 64'(n_done), 64'd1);
      chk("c030b_outst_le4", 64'(max_outst <= 4), 64'd1);
      chk("c030b_gate_err", 64'(gate_err), 64'd0);
      chk("c030b_data_err", 64'(data_err), 64'd0);
      chk("c030b_seq_err", 64'(seq_err), 64'd0);
      chk("c030b_aw_stable_err", 64'(stab_err), 64'd0);
      chk("c030b_wlast_err", 64'(last_err), 64'd0);
      chk("c030b_counts", {32'(n_aw), 32'(n_w)}, {32'd16, 32'd256});
      stall = 1'b0;

      // SLVERR on the second of three responses
      bdelay = 3;
      err_burst = 1;
      start(64'h0, 64'hC00);
      wait_done(400);
      chk("c031_done", 64'(n_done), 64'd1);
      chk("c031_n_aw", 64'(n_aw), 64'd3);
      chk("c031_err_at_done", 64'(err_at_done), 64'd1);
      chk("c031_err_sticky", 64'(error), 64'd1);
      err_burst = -1;
      start(64'h40, 64'h40);
      chk("c031_err_cleared", 64'(error), 64'd0);
      wait_done(100);
      chk("c031_clean_done", {31'd0, err_at_done, 32'(n_done)}, {31'd0, 1'b0, 32'd1});

      // Zero-length request
      start(64'h2000, 64'h0);
      chk("c032_zero_done", 64'(done), 64'd1);
      chk("c032_zero_busy", 64'(busy), 64'd1);
      @(posedge aclk); #1;
      chk("c032_zero_done_1cyc", 64'(done), 64'd0);
      repeat (5) @(posedge aclk);
      #1;
      chk("c032_zero_no_aw", {32'(n_aw), 32'(n_done)}, {32'd0, 32'd1});
      start(64'h2000, 64'h3F);
      repeat (5) @(posedge aclk);
      #1;
      chk("c032_sub64_no_aw", {32'(n_aw), 32'(n_done)}, {32'd0, 32'd1});

      // Reset in the middle of the data phase
      start(64'h0, 64'h400);
      for (int i = 0; i < 100 && n_w < 5; i++) @(posedge aclk);
      #3;
      areset = 1'b1;
      #1;
      chk("c032_rst_mid_w", 64'({awvalid, wvalid, wlast, tready, busy, done, error}), 64'h0);
      @(posedge aclk); #1;
      areset = 1'b0;
      bq_due.delete();
      bq_resp.delete();
      outst = 0;
      n_done = 0;
      repeat (20) @(posedge aclk);
      #1;
      chk("c032_rst_no_done", 64'({busy, 31'(n_done)}), 64'h0);
      start(64'h3000, 64'h80);
      wait_done(100);
      chk("c032_fresh_done", 64'(n_done), 64'd1);
      chk("c032_fresh_aw", {aw_addr[0][55:0], 8'(aw_len[0])}, {56'h3000, 8'd1});
      chk("c032_fresh_counts", {32'(n_aw), 32'(n_w)}, {32'd1, 32'd2});
      chk("c032_fresh_data_err", 64'(data_err), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_write_master.md
AXI_WRITE_MASTER -- requirements
Module: axi_write_master

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, max beats per AXI burst (1..256).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, max bursts with AW accepted but B not yet received (1..15).
REQ-003 SHALL have port aclk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port areset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports wmst_req, input, 1 (one-cycle start pulse); wmst_xfer_addr, input, 64 (start byte address); wmst_xfer_size, input, 64 (byte count).
REQ-006 SHALL have ports axis_slv_tvalid, input, 1; axis_slv_tready, output, 1; axis_slv_tdata, input, 512 (data beats to write).
REQ-007 SHALL have AXI4 AW ports: m_axi_awvalid out 1; m_axi_awready in 1; m_axi_awaddr out 64; m_axi_awlen out 8; m_axi_awsize out 3; m_axi_awburst out 2.
REQ-008 SHALL have AXI4 W ports: m_axi_wvalid out 1; m_axi_wready in 1; m_axi_wdata out 512; m_axi_wstrb out 64; m_axi_wlast out 1.
REQ-009 SHALL have AXI4 B ports: m_axi_bvalid in 1; m_axi_bready out 1; m_axi_bresp in 2.
REQ-010 SHALL have status ports wmst_busy out 1; wmst_done out 1 (one-cycle pulse); wmst_error out 1 (sticky).

Function
REQ-011 SHALL capture address and size on wmst_req in IDLE; wmst_req while busy SHALL be ignored.
REQ-012 SHALL compute total beats = wmst_xfer_size >> 6; addr[5:0] and size[5:0] SHALL be treated as zero (64-byte aligned).
REQ-013 SHALL with total beats 0 pulse wmst_done one cycle after wmst_req, issuing no AXI traffic.
REQ-014 SHALL drive awsize = 3'b110, awburst = 2'b01 (INCR), wstrb = all ones, bready = 1 constantly.
REQ-015 SHALL size each burst = min(remaining beats, BURST_LEN, beats to next 4 KB boundary); awlen = size-1.
REQ-016 SHALL advance burst address by burst_beats*64 after each AW handshake.
REQ-017 SHALL FSM: IDLE -> AW on wmst_req (beats>0); AW -> W on awvalid&awready; W -> AW after wlast beat if beats remain, else -> WAIT_B; WAIT_B -> IDLE when outstanding = 0, pulsing wmst_done that cycle.
REQ-018 SHALL in AW hold awvalid high with stable awaddr/awlen until awready; awvalid SHALL only assert when outstanding < MAX_OUTSTANDING.
REQ-019 SHALL in W drive wvalid = axis_slv_tvalid, axis_slv_tready = m_axi_wready, wdata = axis_slv_tdata combinationally; both low outside W.
REQ-020 SHALL count W beats per burst; wlast high exactly on final beat of each burst.
REQ-021 SHALL increment outstanding on AW handshake, decrement on bvalid; simultaneous events SHALL leave it unchanged.
REQ-022 SHALL set wmst_error on any bresp != 2'b00; cleared only by next accepted wmst_req or reset; transfer continues to completion.
REQ-023 SHALL assert wmst_busy from cycle after accepted wmst_req until wmst_done cycle inclusive.
REQ-024 SHALL tolerate arbitrary awready/wready/tvalid/bvalid stalls with no lost or duplicated beat.

Reset
REQ-025 SHALL on areset asynchronously force IDLE; awvalid, wvalid, wlast, axis_slv_tready, wmst_busy, wmst_done, wmst_error = 0; outstanding and counters = 0.
REQ-026 SHALL on reset mid-transfer abandon it; no completion pulse; next wmst_req starts fresh.

Verification
REQ-027 SHALL cover: addr 0x1000, size 0x400 (16 beats), ready always -> one AW awlen=15, 16 W beats, wlast on 16th, done after B.
REQ-028 SHALL cover: addr 0x0, size 0xFFC0 (1023 beats), BURST_LEN 16 -> 64 bursts (63x awlen=15, last awlen=14), addresses step 0x400.
REQ-029 SHALL cover: addr 0x0FC0, size 0x100 (4 beats) -> two bursts: 0x0FC0 awlen=0, 0x1000 awlen=2.
REQ-030 SHALL cover: random wready/tvalid stalls, B delayed 50 cycles -> outstanding never exceeds 4, data order matches stream.
REQ-031 SHALL cover: bresp=2'b10 on second B of 3-burst transfer -> wmst_error=1 at done; cleared by next wmst_req.
REQ-032 SHALL cover: size 0 -> done one cycle after req, no AW; areset mid-W -> all outputs 0 immediately.
